// File: rtl/dcm_freq_decoder.sv
// dcm_freq_decoder: measures the period of a slow divided clock (clk_in_i) in clk cycles
// and decodes which prog setting (f = base / 2^prog, prog 0..7) it is running at.
// Ports: clk/rst (async active-high reset), clk_in_i (clock under test, async),
//   prog_exp_i (expected prog), prog_det_o/det_valid_o (locked decode), match_o,
//   period_out_o (last measured period), err_o (no-setting pulse), timeout_o (no-edge pulse).
module dcm_freq_decoder #(
  parameter int unsigned BASE_CYCLES = 10_000_000,
  parameter int unsigned TOL         = 1000,
  parameter int unsigned CW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_in_i,
  input  logic [2:0]    prog_exp_i,
  output logic [2:0]    prog_det_o,
  output logic          det_valid_o,
  output logic          match_o,
  output logic [CW-1:0] period_out_o,
  output logic          err_o,
  output logic          timeout_o
);

  // Counter saturation point: one tolerance band past the slowest nominal period.
  localparam logic [63:0]    TMO_L = (64'(BASE_CYCLES) << 7) + 64'(TOL) + 64'd1;
  localparam logic [CW-1:0]  TMO   = TMO_L[CW-1:0];

  typedef enum logic [1:0] {ST_WAIT, ST_MEAS, ST_LOCK} state_t;

  // Window limits are elaboration-time constants; the low bound clamps at 0 so the
  // range test never wraps.
  function automatic logic [CW-1:0] nom_lo(input int k);
    logic [63:0] nom;
    nom = 64'(BASE_CYCLES) << k;
    nom_lo = (nom > 64'(TOL)) ? CW'(nom - 64'(TOL)) : '0;
  endfunction

  function automatic logic [CW-1:0] nom_hi(input int k);
    logic [63:0] nom;
    nom = 64'(BASE_CYCLES) << k;
    nom_hi = CW'(nom + 64'(TOL));
  endfunction

  logic          sync1_q, sync2_q, sync3_q;
  logic          rise;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [2:0]    cand_q, cand_d;
  logic          streak_q, streak_d;
  logic [2:0]    prog_det_q, prog_det_d;
  logic          det_valid_q, det_valid_d;
  logic          match_q, match_d;
  logic [CW-1:0] period_q, period_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          hit;
  logic [2:0]    k_dec;

  assign rise = sync2_q & ~sync3_q;

  // Period P is cnt_q in the cycle the rise is seen.
  assign cnt_d = rise ? CW'(1) : ((cnt_q == TMO) ? TMO : cnt_q + CW'(1));

  // Scan from the top so the lowest matching k is the one that sticks.
  always_comb begin
    hit   = 1'b0;
    k_dec = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (cnt_q >= nom_lo(k) && cnt_q <= nom_hi(k)) begin
        hit   = 1'b1;
        k_dec = 3'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    streak_d    = streak_q;
    prog_det_d  = prog_det_q;
    det_valid_d = det_valid_q;
    period_d    = period_q;
    err_d       = 1'b0;
    tmo_d       = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (rise) begin
          streak_d = 1'b0;
          state_d  = ST_MEAS;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          period_d = cnt_q;
          if (!hit) begin
            err_d    = 1'b1;
            streak_d = 1'b0;
          end else if (streak_q && cand_q == k_dec) begin
            prog_det_d  = k_dec;
            det_valid_d = 1'b1;
            state_d     = ST_LOCK;
          end else begin
            cand_d   = k_dec;
            streak_d = 1'b1;
          end
        end else if (cnt_q == TMO) begin
          tmo_d       = 1'b1;
          det_valid_d = 1'b0;
          streak_d    = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_LOCK: begin
        if (rise) begin
          period_d = cnt_q;
          if (!hit) begin
            err_d       = 1'b1;
            det_valid_d = 1'b0;
            streak_d    = 1'b0;
            state_d     = ST_MEAS;
          end else if (k_dec != prog_det_q) begin
            // A new setting counts as the first of a fresh pair.
            det_valid_d = 1'b0;
            cand_d      = k_dec;
            streak_d    = 1'b1;
            state_d     = ST_MEAS;
          end
        end else if (cnt_q == TMO) begin
          tmo_d       = 1'b1;
          det_valid_d = 1'b0;
          streak_d    = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // match follows the next-state lock so it moves on the same edge as det_valid.
  assign match_d = det_valid_d & (prog_det_d == prog_exp_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_WAIT;
      cand_q      <= 3'd0;
      streak_q    <= 1'b0;
      prog_det_q  <= 3'd0;
      det_valid_q <= 1'b0;
      match_q     <= 1'b0;
      period_q    <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      sync1_q     <= clk_in_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      streak_q    <= streak_d;
      prog_det_q  <= prog_det_d;
      det_valid_q <= det_valid_d;
      match_q     <= match_d;
      period_q    <= period_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign prog_det_o   = prog_det_q;
  assign det_valid_o  = det_valid_q;
  assign match_o      = match_q;
  assign period_out_o = period_q;
  assign err_o        = err_q;
  assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_dcm_freq_decoder.sv
// Testbench for dcm_freq_decoder (BASE_CYCLES=16, TOL=2, TMO=2051).
// Stimulus drives clk_in edges and pushes expected per-edge results into a queue;
// a monitor pops them at the cycle the DUT must show them and checks outputs every cycle.
module tb_dcm_freq_decoder;

  localparam int BASE = 16;
  localparam int TOL  = 2;
  localparam int CW   = 32;
  localparam int TMO  = (BASE << 7) + TOL + 1;
  localparam int LAT  = 3;  // drive edge -> visible output update, in clk cycles

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_in = 1'b0;
  logic [2:0]    prog_exp = 3'd0;
  logic [2:0]    prog_det;
  logic          det_valid;
  logic          match;
  logic [CW-1:0] period_out;
  logic          err;
  logic          timeout;

  dcm_freq_decoder #(.BASE_CYCLES(BASE), .TOL(TOL), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_in_i     (clk_in),
    .prog_exp_i   (prog_exp),
    .prog_det_o   (prog_det),
    .det_valid_o  (det_valid),
    .match_o      (match),
    .period_out_o (period_out),
    .err_o        (err),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  int       cyc = 0;
  logic [2:0] pe_s = 3'd0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    pe_s <= prog_exp;
  end

  typedef struct {
    int cyc;
    bit upd;
    int per;
    bit err;
    bit tmo;
    bit vld;
    int det;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Reference model: a measured period decodes to the lowest k whose nominal
  // window contains it; lock holds whenever the last two decodes hit the same k.
  bit m_wait = 1'b1;
  int m_last = 0;
  bit m_have = 1'b0;
  bit m_hit  = 1'b0;
  int m_k    = 0;

  task automatic decode(input int p, output bit hit, output int k);
    hit = 1'b0;
    k   = 0;
    for (int i = 0; i < 8; i++) begin
      int nom;
      nom = BASE << i;
      if (!hit && p >= nom - TOL && p <= nom + TOL) begin
        hit = 1'b1;
        k   = i;
      end
    end
  endtask

  task automatic model_rise(input int t);
    exp_t e;
    bit   hit;
    int   k;
    e.cyc = t + LAT; e.upd = 0; e.per = 0; e.err = 0; e.tmo = 0; e.vld = 0; e.det = 0;
    if (m_wait) begin
      m_wait = 1'b0;
      m_have = 1'b0;
    end else begin
      decode(t - m_last, hit, k);
      e.upd  = 1'b1;
      e.per  = t - m_last;
      e.err  = !hit;
      e.vld  = hit && m_have && m_hit && (m_k == k);
      e.det  = k;
      m_have = 1'b1;
      m_hit  = hit;
      m_k    = k;
    end
    m_last = t;
    sbq.push_back(e);
  endtask

  // Called at posedge+#1; one full clk_in period of n cycles, rising now.
  task automatic drive_period(input int n);
    clk_in = 1'b1;
    model_rise(cyc);
    for (int i = 0; i < n; i++) begin
      if (i == n / 2) clk_in = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic stop_clock(input int gap);
    exp_t e;
    if (!m_wait && (cyc + gap - m_last) > TMO) begin
      e.cyc = m_last + LAT + TMO; e.upd = 0; e.per = 0; e.err = 0; e.tmo = 1; e.vld = 0; e.det = 0;
      sbq.push_back(e);
      m_wait = 1'b1;
    end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    #1;
    check("rst_det_valid", longint'(det_valid), 0);
    check("rst_prog_det", longint'(prog_det), 0);
    check("rst_match", longint'(match), 0);
    check("rst_period", longint'(period_out), 0);
    check("rst_err", longint'(err), 0);
    check("rst_timeout", longint'(timeout), 0);
    repeat (hold) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_wait = 1'b1;
  endtask

  // Monitor
  initial begin
    bit   ev_vld;
    int   ev_det;
    int   ev_per;
    bit   e_err;
    bit   e_tmo;
    exp_t e;
    ev_vld = 0; ev_det = 0; ev_per = 0;
    forever begin
      @(negedge clk);
      e_err = 0;
      e_tmo = 0;
      if (rst) begin
        sbq.delete();
        ev_vld = 0; ev_det = 0; ev_per = 0;
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          check("event_missed", longint'(sbq[0].cyc), longint'(cyc));
          void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
          e = sbq.pop_front();
          if (e.upd) ev_per = e.per;
          ev_vld = e.vld;
          if (e.vld) ev_det = e.det;
          e_err = e.err;
          e_tmo = e.tmo;
        end
      end
      check("err", longint'(err), longint'(e_err));
      check("timeout", longint'(timeout), longint'(e_tmo));
      check("det_valid", longint'(det_valid), longint'(ev_vld));
      check("period_out", longint'(period_out), longint'(ev_per));
      check("match", longint'(match), longint'(ev_vld && ev_det == int'(pe_s)));
      if (ev_vld) check("prog_det", longint'(prog_det), longint'(ev_det));
    end
  end

  // Stimulus
  initial begin
    #1;
    do_reset(3);
    @(posedge clk); #1;

    // Lock at prog 0
    repeat (5) drive_period(16);
    // Prog 3 with mismatched, then matching prog_exp
    repeat (4) drive_period(128);
    prog_exp = 3'd3;
    repeat (2) drive_period(128);
    // 32 -> 64 transition
    prog_exp = 3'd1;
    repeat (3) drive_period(32);
    repeat (3) drive_period(64);
    // Jitter 15/17, then off-grid 40
    prog_exp = 3'd0;
    repeat (3) begin drive_period(15); drive_period(17); end
    repeat (3) drive_period(40);
    // Tolerance edges: 34 hits, 35 misses
    drive_period(34); drive_period(34); drive_period(35); drive_period(30);
    // Stop while locked, then restart
    repeat (3) drive_period(16);
    stop_clock(2300);
    repeat (4) drive_period(16);
    // Slowest setting, then a period equal to the saturation value
    prog_exp = 3'd7;
    repeat (3) drive_period(2048);
    drive_period(TMO);
    repeat (3) drive_period(16);
    // Reset mid-period while locked
    clk_in = 1'b1;
    model_rise(cyc);
    repeat (8) begin
      @(posedge clk); #1;
      clk_in = 1'b0;
    end
    do_reset(2);
    @(posedge clk); #1;
    repeat (4) drive_period(16);

    // Randomized groups
    for (int g = 0; g < 14; g++) begin
      int k;
      int reps;
      k        = $urandom_range(0, 3);
      reps     = $urandom_range(2, 4);
      prog_exp = 3'($urandom_range(0, 3));
      for (int r = 0; r < reps; r++) begin
        int n;
        if ($urandom_range(0, 5) == 0) n = $urandom_range(10, 150);
        else n = (BASE << k) + $urandom_range(0, 6) - 3;
        drive_period(n);
      end
    end

    repeat (10) @(posedge clk);
    #1;
    check("queue_drained", longint'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
